riscy_control_unit: RTL and testbench
=====================================

// Module: riscy_control_unit
// PURPOSE
//  Multi-cycle FSM sequencing the RISCY datapath (PC, ROM, IR, A/B regs, ALU, RAM, RAM data reg, I/O port).
//  Takes the IR opcode and the ALU zero flag; drives every datapath enable/strobe so exactly one datapath
//  transfer class happens per state. Sits inside RISCY between the IR and the datapath control inputs.
// PARAMETERS
//  OPW       4  opcode width (opcode = INSTR[31:32-OPW], fed in by RISCY)
//  RAM_WAIT  1  extra EXEC cycles held for RAM reads/writes (0..15); RAM_CS/RAM_OE stay stable across them
// PORTS
//  CLK      in   1    clock, all state changes on rising edge
//  RST      in   1    asynchronous, active-low reset
//  OPCODE   in   OPW  opcode field of IR (valid from DECODE onward)
//  ZERO     in   1    ALU zero flag (registered in ALU, valid after an ALU op)
//  IR_EN    out  1    load IR from ROM_OUT
//  PC_EN    out  1    PC increment
//  PC_LOAD  out  1    PC load from IR address field
//  A_EN     out  1    load A (from RDR or port, per opcode)
//  B_EN     out  1    load B from RDR
//  ALU_EN   out  1    ALU computes/registers result
//  ALU_OE   out  1    ALU result drives DATA bus
//  RAM_CS   out  1    RAM chip select
//  RAM_OE   out  1    1=RAM read, 0 with RAM_CS=1 = RAM write
//  RDR_EN   out  1    load RAM data register
//  PDR_EN   out  1    load port direction register from DATA
//  PORT_EN  out  1    port output register loads DATA
//  PORT_RD  out  1    port drives DATA from IO pins
//  HALTED   out  1    core stopped (HALT state)
//  ILLEGAL  out  1    one-cycle pulse in DECODE on undefined opcode
//  STATE    out  3    current state encoding (debug)
// BEHAVIOUR
//  States: RESET=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. RST low -> RESET immediately, all outputs 0.
//  RESET -> FETCH on first edge with RST high. FETCH: IR_EN=1 -> DECODE. DECODE: PC_EN=1 (always, once).
//  DECODE -> HALT if OPCODE=4'hF; else -> EXEC. Undefined opcodes (A..E): ILLEGAL=1, then execute as NOP.
//  Opcodes / EXEC (and WB) actions:
//   0 NOP : EXEC nothing -> FETCH (3 cycles total)
//   1 LDA : EXEC RAM_CS=RAM_OE=RDR_EN=1 for RAM_WAIT+1 cycles; WB A_EN=1 -> FETCH
//   2 LDB : as LDA but WB B_EN=1
//   3 ALU : EXEC ALU_EN=1 -> FETCH
//   4 STA : EXEC RAM_CS=1,RAM_OE=0,ALU_OE=1 for RAM_WAIT+1 cycles -> FETCH
//   5 JMP : EXEC PC_LOAD=1 -> FETCH
//   6 JZ  : EXEC PC_LOAD=ZERO (ZERO sampled in EXEC) -> FETCH
//   7 PDIR: EXEC ALU_OE=1,PDR_EN=1 -> FETCH
//   8 OUT : EXEC ALU_OE=1,PORT_EN=1 -> FETCH
//   9 IN  : EXEC PORT_RD=1 ; WB PORT_RD=1,A_EN=1 -> FETCH
//  Wait counter: 4-bit, cleared entering EXEC, EXEC exits when count==RAM_WAIT (memory ops only).
//  Cycles/instr: NOP/ALU/JMP/JZ/PDIR/OUT=3, IN=4, STA=3+RAM_WAIT, LDA/LDB=4+RAM_WAIT.
//  Outputs: combinational from STATE, latched opcode, counter, ZERO only; glitch-free in intent, no
//   dependence on OPCODE input after DECODE (opcode latched in DECODE).
//  Invariants: PC_EN & PC_LOAD never both 1; ALU_OE & PORT_RD never both 1; RAM_CS=0 outside EXEC.
//  HALT: all strobes 0, HALTED=1, stays until RST low. ILLEGAL never asserted outside DECODE.
//  Reset mid-instruction (any state, any counter value): outputs 0 asynchronously, restart at FETCH; PC/IR
//   reset is the datapath's job.
// TESTING
//  1 Reset: RST=0 mid-EXEC of LDA -> all outputs 0 same cycle, STATE=0; release -> FETCH next edge, IR_EN=1.
//  2 NOP,LDA,ALU,STA with RAM_WAIT=1 -> 3,5,3,4 cycles; RAM_CS high 2 cycles each for LDA/STA, A_EN in WB.
//  3 JZ with ZERO=1 -> PC_LOAD=1 in EXEC; ZERO=0 -> PC_LOAD=0; PC_EN=1 once in DECODE in both cases.
//  4 PDIR then OUT then IN -> PDR_EN, PORT_EN, PORT_RD/A_EN strobes exactly as listed; ALU_OE never with PORT_RD.
//  5 Opcode 4'hB -> ILLEGAL pulses 1 cycle, then NOP timing; opcode 4'hF -> HALTED=1 held 50 cycles, all strobes 0.
//  6 Random opcode stream 1000 instr, RAM_WAIT=0 and 3 -> invariants checked every cycle, cycle counts match table.

Source files
------------

// File: rtl/riscy_control_unit.sv
// Multi-cycle sequencer for the RISCY datapath: FETCH/DECODE/EXEC/WB/HALT with a RAM wait counter.
// Strobes are decoded from the current state, the opcode latched in DECODE, the wait count and ZERO.
`timescale 1ns/1ps
module riscy_control_unit #(
    parameter int OPW      = 4,
    parameter int RAM_WAIT = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] OPCODE,
    input  logic           ZERO,
    output logic           IR_EN,
    output logic           PC_EN,
    output logic           PC_LOAD,
    output logic           A_EN,
    output logic           B_EN,
    output logic           ALU_EN,
    output logic           ALU_OE,
    output logic           RAM_CS,
    output logic           RAM_OE,
    output logic           RDR_EN,
    output logic           PDR_EN,
    output logic           PORT_EN,
    output logic           PORT_RD,
    output logic           HALTED,
    output logic           ILLEGAL,
    output logic [2:0]     STATE
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_LDA  = OPW'(1);
    localparam logic [OPW-1:0] OP_LDB  = OPW'(2);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(3);
    localparam logic [OPW-1:0] OP_STA  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(6);
    localparam logic [OPW-1:0] OP_PDIR = OPW'(7);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(8);
    localparam logic [OPW-1:0] OP_IN   = OPW'(9);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);
    localparam logic [3:0]     WAIT_N  = 4'(RAM_WAIT);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           undef_op;
    logic           mem_op;

    assign undef_op = (OPCODE > OP_IN) && (OPCODE != OP_HALT);
    assign mem_op   = (op_q == OP_LDA) || (op_q == OP_LDB) || (op_q == OP_STA);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // Undefined opcodes are latched as NOP so EXEC stays inert for them.
                cnt_d   = 4'd0;
                op_d    = undef_op ? OP_NOP : OPCODE;
                state_d = (OPCODE == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (mem_op) begin
                    if (cnt_q == WAIT_N) begin
                        state_d = (op_q == OP_STA) ? S_FETCH : S_WB;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (op_q == OP_IN) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_RESET;
            op_q    <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        IR_EN   = 1'b0;
        PC_EN   = 1'b0;
        PC_LOAD = 1'b0;
        A_EN    = 1'b0;
        B_EN    = 1'b0;
        ALU_EN  = 1'b0;
        ALU_OE  = 1'b0;
        RAM_CS  = 1'b0;
        RAM_OE  = 1'b0;
        RDR_EN  = 1'b0;
        PDR_EN  = 1'b0;
        PORT_EN = 1'b0;
        PORT_RD = 1'b0;
        HALTED  = 1'b0;
        ILLEGAL = 1'b0;
        case (state_q)
            S_FETCH:  IR_EN = 1'b1;
            S_DECODE: begin
                PC_EN   = 1'b1;
                ILLEGAL = undef_op;
            end
            S_EXEC: begin
                case (op_q)
                    OP_LDA, OP_LDB: begin
                        RAM_CS = 1'b1;
                        RAM_OE = 1'b1;
                        RDR_EN = 1'b1;
                    end
                    OP_ALU:  ALU_EN = 1'b1;
                    OP_STA: begin
                        RAM_CS = 1'b1;
                        ALU_OE = 1'b1;
                    end
                    OP_JMP:  PC_LOAD = 1'b1;
                    OP_JZ:   PC_LOAD = ZERO;
                    OP_PDIR: begin
                        ALU_OE = 1'b1;
                        PDR_EN = 1'b1;
                    end
                    OP_OUT: begin
                        ALU_OE  = 1'b1;
                        PORT_EN = 1'b1;
                    end
                    OP_IN:   PORT_RD = 1'b1;
                    default: ;
                endcase
            end
            S_WB: begin
                case (op_q)
                    OP_LDA:  A_EN = 1'b1;
                    OP_LDB:  B_EN = 1'b1;
                    OP_IN: begin
                        PORT_RD = 1'b1;
                        A_EN    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:   HALTED = 1'b1;
            default:  ;
        endcase
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_riscy_control_unit.sv
// Scoreboard bench for riscy_control_unit: three instances (RAM_WAIT 1, 0, 3) with per-instruction
// strobe-count records predicted from the opcode table and checked by per-instance monitors.
`timescale 1ns/1ps
module tb_riscy_control_unit;

    typedef struct packed {
        logic [7:0] cyc, ir, pc, pcl, a, b, alue, aluoe, cs, oe, rdr, pdr, port, prd, ill;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n;
    logic [3:0] opc [3];
    logic [2:0] zr;
    wire  [2:0] ir_en, pc_en, pc_load, a_en, b_en, alu_en, alu_oe, ram_cs, ram_oe;
    wire  [2:0] rdr_en, pdr_en, port_en, port_rd, halted, illegal;
    wire  [2:0] st [3];

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   abort_run = 1'b0;
    rec_t exp_q [3][$];

    function automatic int rw_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscy_control_unit #(.OPW(4), .RAM_WAIT(rw_of(g))) u_dut (
            .CLK(clk), .RST(rst_n[g]), .OPCODE(opc[g]), .ZERO(zr[g]),
            .IR_EN(ir_en[g]), .PC_EN(pc_en[g]), .PC_LOAD(pc_load[g]), .A_EN(a_en[g]),
            .B_EN(b_en[g]), .ALU_EN(alu_en[g]), .ALU_OE(alu_oe[g]), .RAM_CS(ram_cs[g]),
            .RAM_OE(ram_oe[g]), .RDR_EN(rdr_en[g]), .PDR_EN(pdr_en[g]), .PORT_EN(port_en[g]),
            .PORT_RD(port_rd[g]), .HALTED(halted[g]), .ILLEGAL(illegal[g]), .STATE(st[g])
        );
    end

    function automatic logic [14:0] outv(input int d);
        return {ir_en[d], pc_en[d], pc_load[d], a_en[d], b_en[d], alu_en[d], alu_oe[d], ram_cs[d],
                ram_oe[d], rdr_en[d], pdr_en[d], port_en[d], port_rd[d], halted[d], illegal[d]};
    endfunction

    // Expected strobe totals and length of one instruction, straight from the opcode table.
    function automatic rec_t model(input logic [3:0] op, input int rw, input logic z);
        rec_t r;
        r     = '0;
        r.cyc = 8'd3;
        r.ir  = 8'd1;
        r.pc  = 8'd1;
        case (op)
            4'h0: ;
            4'h1, 4'h2: begin
                r.cyc = 8'(4 + rw);
                r.cs  = 8'(rw + 1);
                r.oe  = 8'(rw + 1);
                r.rdr = 8'(rw + 1);
                if (op == 4'h1) r.a = 8'd1;
                else            r.b = 8'd1;
            end
            4'h3: r.alue = 8'd1;
            4'h4: begin
                r.cyc   = 8'(3 + rw);
                r.cs    = 8'(rw + 1);
                r.aluoe = 8'(rw + 1);
            end
            4'h5: r.pcl = 8'd1;
            4'h6: r.pcl = {7'd0, z};
            4'h7: begin r.aluoe = 8'd1; r.pdr  = 8'd1; end
            4'h8: begin r.aluoe = 8'd1; r.port = 8'd1; end
            4'h9: begin r.cyc = 8'd4; r.prd = 8'd2; r.a = 8'd1; end
            default: r.ill = 8'd1;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %h required %h", nm, $time, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin : mon
            rec_t acc;
            bit   on;
            logic bad;
            acc = '0;
            on  = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    on = 1'b0;
                    chk($sformatf("reset_outs[%0d]", g), 128'({outv(g), st[g]}), 128'(0));
                end else begin
                    bad = (pc_en[g] & pc_load[g]) | (alu_oe[g] & port_rd[g])
                        | (ram_cs[g] & (st[g] != 3'd3)) | (illegal[g] & (st[g] != 3'd2))
                        | (halted[g] ^ (st[g] == 3'd5));
                    chk($sformatf("invariant[%0d] st=%0d", g, st[g]), 128'(bad), 128'(0));
                    if (ir_en[g]) begin
                        if (on) begin
                            chk($sformatf("sb_pending[%0d]", g), 128'(exp_q[g].size() != 0), 128'(1));
                            if (exp_q[g].size() != 0)
                                chk($sformatf("instr_rec[%0d]", g), 128'(acc), 128'(exp_q[g].pop_front()));
                        end
                        acc = '0;
                        on  = 1'b1;
                    end
                    if (on) begin
                        acc.cyc   += 8'd1;
                        acc.ir    += 8'(ir_en[g]);
                        acc.pc    += 8'(pc_en[g]);
                        acc.pcl   += 8'(pc_load[g]);
                        acc.a     += 8'(a_en[g]);
                        acc.b     += 8'(b_en[g]);
                        acc.alue  += 8'(alu_en[g]);
                        acc.aluoe += 8'(alu_oe[g]);
                        acc.cs    += 8'(ram_cs[g]);
                        acc.oe    += 8'(ram_oe[g]);
                        acc.rdr   += 8'(rdr_en[g]);
                        acc.pdr   += 8'(pdr_en[g]);
                        acc.port  += 8'(port_en[g]);
                        acc.prd   += 8'(port_rd[g]);
                        acc.ill   += 8'(illegal[g]);
                    end
                end
            end
        end
    end

    task automatic wait_fetch(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir_en[d]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at a FETCH negedge; opcode is scrambled once the DUT has latched it.
    task automatic issue_here(input int d, input logic [3:0] op, input logic z, input bit push);
        opc[d] = op;
        zr[d]  = z;
        if (push) exp_q[d].push_back(model(op, rw_of(d), z));
        @(negedge clk);
        @(negedge clk);
        opc[d] = 4'($urandom);
    endtask

    task automatic send(input int d, input logic [3:0] op, input logic z, input bit push);
        bit ok;
        if (abort_run) return;
        wait_fetch(d, ok);
        chk($sformatf("fetch_seen[%0d]", d), 128'(ok), 128'(1));
        if (!ok) begin
            abort_run = 1'b1;
            return;
        end
        issue_here(d, op, z, push);
    endtask

    task automatic stream(input int d, input int n);
        bit ok;
        @(negedge clk);
        rst_n[d] = 1'b1;
        for (int i = 0; i < n; i++)
            send(d, 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'b1);
        wait_fetch(d, ok);
        chk($sformatf("final_fetch[%0d]", d), 128'(ok), 128'(1));
        opc[d] = 4'h0;
        @(negedge clk);
        chk($sformatf("sb_drain[%0d]", d), 128'(exp_q[d].size()), 128'(0));
        rst_n[d] = 1'b0;
    endtask

    logic [4:0] dir_seq [13] = '{5'h01, 5'h03, 5'h04, 5'h16, 5'h06, 5'h05, 5'h07,
                                 5'h08, 5'h09, 5'h02, 5'h0B, 5'h00, 5'h19};

    initial begin
        rst_n = 3'b000;
        zr    = 3'b000;
        for (int i = 0; i < 3; i++) opc[i] = 4'h0;
        repeat (3) @(negedge clk);

        // Reset in the middle of an LDA memory access.
        rst_n[0] = 1'b1;
        send(0, 4'h0, 1'b0, 1'b1);
        send(0, 4'h1, 1'b0, 1'b0);
        chk("lda_exec", 128'({st[0], ram_cs[0]}), 128'({3'd3, 1'b1}));
        rst_n[0] = 1'b0;
        #1;
        chk("async_reset", 128'({outv(0), st[0]}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("fetch_after_reset", 128'({st[0], outv(0)}), 128'({3'd1, 15'h4000}));
        issue_here(0, 4'h0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) send(0, dir_seq[i][3:0], dir_seq[i][4], 1'b1);

        // HALT must hold with every strobe low until reset.
        send(0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            chk("halt_hold", 128'({outv(0), st[0]}), 128'({15'h0002, 3'd5}));
            @(negedge clk);
        end
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("sb_drain_directed", 128'(exp_q[0].size()), 128'(0));

        fork
            stream(0, 300);
            stream(1, 1000);
            stream(2, 1000);
        join
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
